fft_frame_loader: RTL and testbench
===================================

# fft_frame_loader

Upstream stage of the Radix-16 FFT datapath. It accepts the raw QKD key stream as one 64-bit word per handshake and packs 16 consecutive words into the 1024-bit lane vector consumed by `Radix16FFT.data_in`. Unfilled lanes of a short final frame are zero-padded. The block is double-buffered (ping-pong), so the next frame fills while the current frame is held stable for the FFT.

## Interface

Parameters:
- `DATA_WIDTH`, 64: lane width in bits.
- `RADIX`, 16: lanes per frame.
- `CNT_WIDTH`, 16: width of the frame counter.

Ports:
- `clk`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: input word valid.
- `in_ready`  out  1: loader can accept a word.
- `in_data`  in  DATA_WIDTH: key word.
- `in_last`  in  1: this word closes the frame early.
- `out_valid`  out  1: a complete frame is presented.
- `out_ready`  in  1: FFT stage takes the frame.
- `out_data`  out  DATA_WIDTH*RADIX: frame; lane k occupies `out_data[k*DATA_WIDTH +: DATA_WIDTH]`.
- `out_lanes`  out  5: number of real (non-pad) lanes in the frame, 1..16.
- `frame_count`  out  CNT_WIDTH: count of frames delivered; wraps modulo 2^CNT_WIDTH.

## Operation

- There are two buffers, B0 and B1. Each buffer has a state: EMPTY, FILLING or FULL. `wr_sel` selects the buffer being filled and `rd_sel` selects the buffer being presented. Both select 0 after reset.
- Input handshake: a word is accepted when `in_valid && in_ready`. `in_ready = (state[wr_sel] != FULL)`.
- The write-lane counter `lane` runs 0..15.
  - The first accepted word goes to lane 0. That write also zeroes lanes 1..15 of the same buffer, so padding needs no extra cycles. The buffer moves EMPTY→FILLING.
  - The frame closes when the accepted word has `lane == 15` or `in_last == 1`. The buffer goes →FULL, `out_lanes` for that buffer latches `lane+1`, `lane` resets to 0, and `wr_sel` toggles.
  - A single-word frame goes EMPTY→FULL directly.
- Output: `out_valid = (state[rd_sel] == FULL)`. `out_data` and `out_lanes` come from buffer `rd_sel`.
  - On `out_valid && out_ready`, the buffer goes FULL→EMPTY, `rd_sel` toggles and `frame_count` increments.
- While `out_valid` is high, `out_data` and `out_lanes` hold stable until the handshake completes. The input side never writes the `rd_sel` buffer while it is FULL.
- Frames are delivered in strict arrival order. No frame is dropped or reordered.

Boundary conditions:
- A close on the input side and a handshake on the output side in the same cycle both take effect. The freed buffer is visible to `in_ready` on the next cycle.
- Both buffers FULL: `in_ready = 0`. Words are held upstream.
- `in_last` arriving with lane 15 is a normal full frame, `out_lanes = 16`.
- `frame_count` wraps from 0xFFFF to 0x0000 with no flag.
- Reset asserted mid-frame: the partial frame is discarded, all state is cleared, and no spurious `out_valid` is produced after release.

Reset values: `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `out_lanes = 0`, `frame_count = 0`, both buffers EMPTY, `lane = 0`.

## Timing

- Latency: the word that closes a frame, accepted at edge N, gives `out_valid = 1` after edge N (visible in cycle N+1).
- Throughput: with `out_ready` held high, one word is accepted per cycle indefinitely. Each frame occupies 16 cycles of input, and the output handshake completes within the next fill period.
- `in_ready` and `out_valid` are decoded from registered state only, with no combinational path from `in_valid` or `out_ready`.
- Data and lane registers are enabled flops with no reset-dependent datapath muxing beyond the asynchronous clear.

## Structure

- Shared package (`fft_pkg`):
  - `DATA_WIDTH` and `RADIX` constants, shared with `Radix16FFT`.
  - The buffer-state enum (EMPTY/FILLING/FULL).
  - A lane-index type (4 bits) and a lane-count type (5 bits).
- One natural sub-module: `frame_buffer`. It holds one 16-lane register bank with a lane write-enable, the clear-on-lane-0 behaviour, and a latched `out_lanes`. It is instantiated twice. Control (`wr_sel`, `rd_sel`, `lane`, `frame_count`) lives in the top level.

## Test plan

- Full frame: 16 words 0x1..0x10 with `out_ready = 1` → one cycle after the 16th accept, `out_valid = 1`, lane k = k+1, `out_lanes = 16`, and `frame_count` becomes 1 after the handshake.
- Short frame: 3 words 0xA, 0xB, 0xC, with `in_last` on 0xC → lanes 0..2 = A, B, C, lanes 3..15 = 0, `out_lanes = 3`. A following 16-word frame has no residue from the short frame.
- Backpressure: `out_ready = 0` and 40 words offered → exactly 32 accepted, `in_ready = 0` from then on, and `out_data` stable. Then `out_ready = 1` → frames 1, 2, 3 emerge in order.
- Simultaneous events: B1 closes in the same cycle that B0 is handshaken → both take effect, `in_ready = 1` next cycle, and there is no lost or duplicated frame.
- Reset mid-frame: assert `rst = 0` after 7 words, then release → all outputs at reset values, and a fresh 16-word frame is delivered correctly with `frame_count = 1`.
- Wrap: preload via 65536 single-word frames (`in_last` on every word) → `frame_count` returns to 0 and `out_lanes = 1` each frame.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types and constants for the Radix-16 FFT front end.
// The lane width and radix are common to fft_frame_loader and Radix16FFT.
package fft_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int RADIX      = 16;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } buf_state_t;

  typedef logic [3:0] lane_idx_t;
  typedef logic [4:0] lane_cnt_t;

  // Number of real lanes in a frame whose last word landed in lane idx.
  function automatic lane_cnt_t lane_count(input lane_idx_t idx);
    return lane_cnt_t'(idx) + lane_cnt_t'(1);
  endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Word-in / frame-out stream bundle between the key source, the frame loader and the FFT.
interface fft_frame_loader_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RADIX      = 16,
  parameter int CNT_WIDTH  = 16
);

  logic                        in_valid;
  logic                        in_ready;
  logic [DATA_WIDTH-1:0]       in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [DATA_WIDTH*RADIX-1:0] out_data;
  lane_cnt_t                   out_lanes;
  logic [CNT_WIDTH-1:0]        frame_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_lanes, frame_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_lanes, frame_count
  );

endinterface

// File: rtl/fft_frame_loader_frame_buffer.sv
// One 16-lane frame register bank with its EMPTY/FILLING/FULL state and latched lane count.
// Writing lane 0 clears every other lane, so short frames come out zero-padded.
module frame_buffer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RADIX      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  lane_idx_t                   wr_lane,
  input  logic [DATA_WIDTH-1:0]       wr_data,
  input  logic                        wr_close,
  input  logic                        rd_done,
  output buf_state_t                  state,
  output logic [DATA_WIDTH*RADIX-1:0] data,
  output lane_cnt_t                   lanes
);

  buf_state_t state_reg;
  buf_state_t state_next;
  lane_cnt_t  lanes_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // A write and a read-completion never target the same buffer in one cycle.
  always_comb begin
    state_next = state_reg;
    if (wr_en) begin
      state_next = wr_close ? FULL : FILLING;
    end else if (rd_done) begin
      state_next = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lanes_reg <= '0;
    end else if (wr_en && wr_close) begin
      lanes_reg <= lane_count(wr_lane);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < RADIX; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          lane_reg <= '0;
        end else if (wr_en && (wr_lane == lane_idx_t'(gi))) begin
          lane_reg <= wr_data;
        end else if (wr_en && (wr_lane == '0)) begin
          lane_reg <= '0;
        end
      end

      assign data[gi*DATA_WIDTH +: DATA_WIDTH] = lane_reg;
    end
  endgenerate

  assign state = state_reg;
  assign lanes = lanes_reg;

endmodule

// File: rtl/fft_frame_loader.sv
// Ping-pong loader packing 64-bit key words into 16-lane frames for the Radix-16 FFT.
// wr_sel/rd_sel alternate between the two banks, so frames leave in arrival order.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int RADIX      = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  fft_frame_loader_if.slave bus
);

  localparam lane_idx_t LAST_LANE = lane_idx_t'(RADIX - 1);

  logic                 wr_sel_reg, wr_sel_next;
  logic                 rd_sel_reg, rd_sel_next;
  lane_idx_t            lane_reg, lane_next;
  logic [CNT_WIDTH-1:0] frame_count_reg, frame_count_next;

  buf_state_t                  buf_state [2];
  logic [DATA_WIDTH*RADIX-1:0] buf_data  [2];
  lane_cnt_t                   buf_lanes [2];
  logic [1:0]                  wr_en;
  logic [1:0]                  rd_done;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic close;
  logic deliver;

  // Handshake flags decode only registered buffer state.
  assign in_ready  = (buf_state[wr_sel_reg] != FULL);
  assign out_valid = (buf_state[rd_sel_reg] == FULL);
  assign accept    = bus.in_valid && in_ready;
  assign close     = accept && ((lane_reg == LAST_LANE) || bus.in_last);
  assign deliver   = out_valid && bus.out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      assign wr_en[gi]   = accept  && (wr_sel_reg == 1'(gi));
      assign rd_done[gi] = deliver && (rd_sel_reg == 1'(gi));

      frame_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .RADIX      (RADIX)
      ) u_frame_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en[gi]),
        .wr_lane  (lane_reg),
        .wr_data  (bus.in_data),
        .wr_close (close),
        .rd_done  (rd_done[gi]),
        .state    (buf_state[gi]),
        .data     (buf_data[gi]),
        .lanes    (buf_lanes[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_reg      <= 1'b0;
      rd_sel_reg      <= 1'b0;
      lane_reg        <= '0;
      frame_count_reg <= '0;
    end else begin
      wr_sel_reg      <= wr_sel_next;
      rd_sel_reg      <= rd_sel_next;
      lane_reg        <= lane_next;
      frame_count_reg <= frame_count_next;
    end
  end

  always_comb begin
    wr_sel_next      = wr_sel_reg;
    rd_sel_next      = rd_sel_reg;
    lane_next        = lane_reg;
    frame_count_next = frame_count_reg;
    if (accept) begin
      lane_next = close ? lane_idx_t'(0) : lane_reg + lane_idx_t'(1);
    end
    if (close) begin
      wr_sel_next = ~wr_sel_reg;
    end
    if (deliver) begin
      rd_sel_next      = ~rd_sel_reg;
      frame_count_next = frame_count_reg + CNT_WIDTH'(1);
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = buf_data[rd_sel_reg];
  assign bus.out_lanes   = buf_lanes[rd_sel_reg];
  assign bus.frame_count = frame_count_reg;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: packing, padding, backpressure, ordering, reset and counter wrap.
// Accepted words feed a packing model whose frames are queued and popped at each output handshake.
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int DW = 64;
  localparam int RX = 16;
  localparam int CW = 16;
  localparam int FW = DW * RX;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fft_frame_loader_if #(.DATA_WIDTH(DW), .RADIX(RX), .CNT_WIDTH(CW)) bus ();

  fft_frame_loader #(.DATA_WIDTH(DW), .RADIX(RX), .CNT_WIDTH(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [FW-1:0] data;
    logic [4:0]    lanes;
  } frame_t;

  frame_t        sb_q[$];
  logic [FW-1:0] build_data;
  int            build_lanes = 0;
  logic [CW-1:0] exp_count   = '0;
  int            n_checks    = 0;
  int            n_fail      = 0;
  bit            mon_en      = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_frame(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      for (int k = 0; k < RX; k++) begin
        if (obs[k*DW +: DW] !== exp[k*DW +: DW]) begin
          $error("FAIL %s lane %0d observed=%0h expected=%0h", tag, k, obs[k*DW +: DW], exp[k*DW +: DW]);
          break;
        end
      end
    end
  endtask

  task automatic model_accept(input logic [DW-1:0] d, input logic last);
    frame_t f;
    if (build_lanes == 0) build_data = '0;
    build_data[build_lanes*DW +: DW] = d;
    build_lanes++;
    if (last || build_lanes == RX) begin
      f.data  = build_data;
      f.lanes = 5'(build_lanes);
      sb_q.push_back(f);
      build_lanes = 0;
    end
  endtask

  // Called just after a rising edge; offers one word for up to budget cycles.
  task automatic send(input logic [DW-1:0] d, input logic last, input int budget, output bit ok);
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    for (int c = 0; c < budget && !ok; c++) begin
      if (bus.in_ready) begin
        ok = 1'b1;
        @(posedge clk);
        #1;
        model_accept(d, last);
      end else begin
        @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic put(input logic [DW-1:0] d, input logic last);
    bit ok;
    send(d, last, 64, ok);
    chk("accept", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (sb_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    chk("drain", 64'(done), 64'd1);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    frame_t f;
    if (mon_en && rst && bus.out_valid && bus.out_ready) begin
      chk("frame_expected", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        f = sb_q.pop_front();
        chk_frame("out_data", bus.out_data, f.data);
        chk("out_lanes", 64'(bus.out_lanes), 64'(f.lanes));
        chk("frame_count", 64'(bus.frame_count), 64'(exp_count));
      end
      exp_count = exp_count + 1'b1;
    end
  end

  initial begin
    logic [FW-1:0] exp_f;
    int            acc;
    bit            ok;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk_frame("rst_out_data", bus.out_data, '0);
    chk("rst_out_lanes", 64'(bus.out_lanes), 64'd0);
    chk("rst_frame_count", 64'(bus.frame_count), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Full frame 0x1..0x10, out_valid one cycle after the 16th accept
    bus.out_ready = 1'b1;
    for (int k = 0; k < RX; k++) put(64'(k + 1), 1'b0);
    @(negedge clk);
    exp_f = '0;
    for (int k = 0; k < RX; k++) exp_f[k*DW +: DW] = 64'(k + 1);
    chk("full_valid", 64'(bus.out_valid), 64'd1);
    chk("full_lanes", 64'(bus.out_lanes), 64'd16);
    chk_frame("full_data", bus.out_data, exp_f);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("full_count", 64'(bus.frame_count), 64'd1);
    chk("full_valid_after", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Short frame A,B,C zero-padded, then full and short frames with no residue
    bus.out_ready = 1'b0;
    put(64'hA, 1'b0);
    put(64'hB, 1'b0);
    put(64'hC, 1'b1);
    @(negedge clk);
    exp_f = '0;
    exp_f[0*DW +: DW] = 64'hA;
    exp_f[1*DW +: DW] = 64'hB;
    exp_f[2*DW +: DW] = 64'hC;
    chk("short_valid", 64'(bus.out_valid), 64'd1);
    chk("short_lanes", 64'(bus.out_lanes), 64'd3);
    chk_frame("short_data", bus.out_data, exp_f);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < RX; k++) put(64'h100 + 64'(k), 1'b0);
    put(64'hD, 1'b0);
    put(64'hE, 1'b1);
    drain();

    // Backpressure: 40 offered, 32 accepted, presented frame held
    bus.out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 40; i++) begin
      send(64'h1000 + 64'(i), 1'b0, 1, ok);
      if (ok) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'd32);
    exp_f = '0;
    for (int k = 0; k < RX; k++) exp_f[k*DW +: DW] = 64'h1000 + 64'(k);
    @(negedge clk);
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    chk_frame("bp_frame1", bus.out_data, exp_f);
    repeat (5) @(negedge clk);
    chk("bp_in_ready_hold", 64'(bus.in_ready), 64'd0);
    chk_frame("bp_frame1_hold", bus.out_data, exp_f);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < RX; k++) put(64'h2000 + 64'(k), 1'b0);
    drain();

    // Close of the fill buffer coincides with handshake of the other
    bus.out_ready = 1'b0;
    for (int k = 0; k < RX; k++) put(64'h3000 + 64'(k), 1'b0);
    for (int k = 0; k < RX - 1; k++) put(64'h4000 + 64'(k), 1'b0);
    bus.out_ready = 1'b1;
    put(64'h400F, 1'b0);
    @(negedge clk);
    chk("sim_in_ready", 64'(bus.in_ready), 64'd1);
    chk("sim_out_valid", 64'(bus.out_valid), 64'd1);
    chk("sim_out_lanes", 64'(bus.out_lanes), 64'd16);
    @(posedge clk);
    #1;
    drain();

    // Reset mid-frame discards the partial frame and clears the counter
    for (int k = 0; k < 7; k++) put(64'h5000 + 64'(k), 1'b0);
    rst = 1'b0;
    build_lanes = 0;
    sb_q.delete();
    exp_count = '0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    end
    chk_frame("mid_rst_out_data", bus.out_data, '0);
    chk("mid_rst_out_lanes", 64'(bus.out_lanes), 64'd0);
    chk("mid_rst_frame_count", 64'(bus.frame_count), 64'd0);
    @(posedge clk);
    #1;
    for (int k = 0; k < RX; k++) put(64'h6000 + 64'(k), 1'b0);
    drain();
    @(negedge clk);
    chk("mid_rst_count_after", 64'(bus.frame_count), 64'd1);
    @(posedge clk);
    #1;

    // Single-word frames until the frame counter wraps back to zero
    for (int i = 0; i < 65535; i++) put({$urandom, $urandom}, 1'b1);
    drain();
    @(negedge clk);
    chk("wrap_count", 64'(bus.frame_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
